// File: rtl/teclado.sv
// teclado: 4x4 keypad scanner with debounce, 20-digit code buffer and confirm strobe
module teclado #(
  parameter int SCAN_CYCLES = 100,
  parameter int DEBOUNCE_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        teclado_en,
  input  logic [3:0]  col_matrix,
  output logic [3:0]  lin_matrix,
  output logic [79:0] digitos_value,
  output logic        digitos_valid
);
  localparam logic [2:0] IDLE = 3'd0, SCAN = 3'd1, DEB_PRESS = 3'd2, HELD = 3'd3, DEB_REL = 3'd4;
  localparam int SW = $clog2(SCAN_CYCLES + 1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  // nibble {row,col}: digits as-is, A-D as A-D, '*' = E, '#' = F
  localparam logic [63:0] KEYMAP = 64'hDF0E_C987_B654_A321;
  localparam logic [3:0] KEY_STAR = 4'hE, KEY_HASH = 4'hF;
  logic [2:0]    state;
  logic [1:0]    row, col_idx;
  logic [3:0]    col_m, col_s, pat, code;
  logic [SW-1:0] scan_cnt;
  logic [DW-1:0] deb_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [79:0]   buffer;
  logic [4:0]    count;
  logic          one_low, deb_last, accept;
  always_comb begin
    one_low = (col_s == 4'hE) || (col_s == 4'hD) || (col_s == 4'hB) || (col_s == 4'h7);
    col_idx = (col_s == 4'hE) ? 2'd0 : (col_s == 4'hD) ? 2'd1 : (col_s == 4'hB) ? 2'd2 : 2'd3;
    deb_last = deb_cnt == DEB_LAST;
    accept = teclado_en && state == DEB_PRESS && col_s == pat && deb_last;
  end
  assign lin_matrix = (state == IDLE) ? 4'hF : ~(4'b0001 << row);
  always_ff @(posedge clk) begin
    if (rst) begin
      col_m <= 4'hF;
      col_s <= 4'hF;
      state <= IDLE;
      row <= '0;
      scan_cnt <= '0;
      deb_cnt <= '0;
      tmo_cnt <= '0;
      pat <= 4'hF;
      code <= 4'h0;
      buffer <= '1;
      count <= '0;
      digitos_value <= '1;
      digitos_valid <= 1'b0;
    end else begin
      col_m <= col_matrix;
      col_s <= col_m;
      digitos_valid <= 1'b0;
      if (!teclado_en) begin
        state <= IDLE;
        row <= '0;
        scan_cnt <= '0;
        deb_cnt <= '0;
        tmo_cnt <= '0;
        buffer <= '1;
        count <= '0;
      end else begin
        case (state)
          IDLE: begin
            state <= SCAN;
            row <= '0;
            scan_cnt <= '0;
          end
          SCAN: begin
            if (one_low) begin
              state <= DEB_PRESS;
              pat <= col_s;
              code <= KEYMAP[{row, col_idx, 2'b00} +: 4];
              deb_cnt <= '0;
              scan_cnt <= '0;
            end else begin
              scan_cnt <= (scan_cnt == SCAN_LAST) ? '0 : scan_cnt + 1'b1;
              row <= (scan_cnt == SCAN_LAST) ? row + 2'd1 : row;
            end
          end
          DEB_PRESS: begin
            state <= (col_s != pat) ? SCAN : deb_last ? HELD : DEB_PRESS;
            deb_cnt <= (col_s != pat || deb_last) ? '0 : deb_cnt + 1'b1;
          end
          HELD: begin
            state <= (col_s == 4'hF) ? DEB_REL : HELD;
            deb_cnt <= '0;
          end
          DEB_REL: begin
            state <= (col_s != 4'hF) ? HELD : deb_last ? SCAN : DEB_REL;
            deb_cnt <= (col_s != 4'hF || deb_last) ? '0 : deb_cnt + 1'b1;
          end
          default: state <= IDLE;
        endcase
        // an accepted key always wins over a simultaneous timeout expiry
        if (accept) begin
          tmo_cnt <= '0;
          if (code <= 4'd9) begin
            buffer <= {buffer[75:0], code};
            count <= (count == 5'd20) ? 5'd20 : count + 5'd1;
          end else if (code == KEY_HASH) begin
            digitos_value <= buffer;
            digitos_valid <= 1'b1;
            buffer <= '1;
            count <= '0;
          end else if (code == KEY_STAR) begin
            buffer <= '1;
            count <= '0;
          end
        end else if (count != 5'd0) begin
          if (tmo_cnt == TMO_LAST) begin
            buffer <= '1;
            count <= '0;
            tmo_cnt <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end else begin
          tmo_cnt <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_teclado.sv
// tb_teclado: directed keypad sequences against hand-computed codes, with a row-switch keypad model
module tb_teclado;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        teclado_en = 1'b0;
  logic [3:0]  col_matrix;
  logic [3:0]  lin_matrix;
  logic [79:0] digitos_value;
  logic        digitos_valid;
  logic [15:0] keys = '0;
  int          errors = 0;
  int          checks = 0;
  int          strobes = 0;
  localparam logic [79:0] ALL_F = {80{1'b1}};
  localparam int K_STAR = 12, K_HASH = 14;

  teclado #(.SCAN_CYCLES(4), .DEBOUNCE_CYCLES(8), .TIMEOUT_CYCLES(200)) dut (
    .clk(clk), .rst(rst), .teclado_en(teclado_en), .col_matrix(col_matrix),
    .lin_matrix(lin_matrix), .digitos_value(digitos_value), .digitos_valid(digitos_valid)
  );

  always #5 clk = ~clk;

  // each pressed key shorts its row to its column
  always_comb begin
    col_matrix = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!lin_matrix[r] && keys[r*4+c]) col_matrix[c] = 1'b0;
  end

  always @(negedge clk) if (digitos_valid) strobes++;

  function automatic int kidx(input int d);
    return (d == 0) ? 13 : (d <= 3) ? d - 1 : (d <= 6) ? d : d + 1;
  endfunction

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic press_mask(input logic [15:0] m, input int hold);
    keys = m;
    repeat (hold) @(negedge clk);
    keys = '0;
    repeat (30) @(negedge clk);
  endtask

  task automatic press(input int idx, input int hold = 50);
    press_mask(16'b1 << idx, hold);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_lin", {76'd0, lin_matrix}, 80'hF);
    chk("reset_valid", {79'd0, digitos_valid}, 80'd0);
    chk("reset_value", digitos_value, ALL_F);
    rst = 1'b0;
    teclado_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk($sformatf("rotate_%0d", i), {76'd0, lin_matrix}, {76'd0, ~(4'b0001 << (i / 4))});
    end

    // 1,2,3,4 then '#'
    strobes = 0;
    for (int d = 1; d <= 4; d++) press(kidx(d));
    chk("t1_no_early_strobe", 80'(strobes), 80'd0);
    press(K_HASH);
    chk("t1_strobes", 80'(strobes), 80'd1);
    chk("t1_value", digitos_value, 80'hFFFFFFFFFFFFFFFF1234);

    // bouncing '5'
    strobes = 0;
    for (int i = 0; i < 10; i++) begin
      keys = (i % 2 == 0) ? (16'b1 << kidx(5)) : 16'd0;
      repeat (3) @(negedge clk);
    end
    keys = 16'b1 << kidx(5);
    repeat (50) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      keys = (i % 2 == 0) ? 16'd0 : (16'b1 << kidx(5));
      repeat (3) @(negedge clk);
    end
    keys = '0;
    repeat (30) @(negedge clk);
    press(K_HASH);
    chk("t2_strobes", 80'(strobes), 80'd1);
    chk("t2_value", digitos_value, 80'hFFFFFFFFFFFFFFFFFFF5);

    // 22 digits: oldest two drop out
    strobes = 0;
    for (int i = 0; i < 22; i++) press(kidx(i % 10));
    press(K_HASH);
    chk("t3_strobes", 80'(strobes), 80'd1);
    chk("t3_value", digitos_value, 80'h23456789012345678901);

    // '*' clears without strobe
    strobes = 0;
    press(kidx(7));
    press(kidx(8));
    press(K_STAR);
    chk("t4_star_no_strobe", 80'(strobes), 80'd0);
    chk("t4_value_held", digitos_value, 80'h23456789012345678901);
    press(kidx(9));
    press(K_HASH);
    chk("t4_strobes", 80'(strobes), 80'd1);
    chk("t4_value", digitos_value, 80'hFFFFFFFFFFFFFFFFFFF9);

    // timeout discards the buffer but leaves digitos_value alone
    strobes = 0;
    press(kidx(6));
    repeat (250) @(negedge clk);
    chk("t5_timeout_no_strobe", 80'(strobes), 80'd0);
    chk("t5_timeout_value_held", digitos_value, 80'hFFFFFFFFFFFFFFFFFFF9);
    press(K_HASH);
    chk("t5_timeout_value", digitos_value, ALL_F);

    // one-cycle disable clears the buffer
    strobes = 0;
    press(kidx(6));
    teclado_en = 1'b0;
    @(negedge clk);
    chk("t5_lin_disabled", {76'd0, lin_matrix}, 80'hF);
    teclado_en = 1'b1;
    repeat (5) @(negedge clk);
    press(K_HASH);
    chk("t5_disable_strobes", 80'(strobes), 80'd1);
    chk("t5_disable_value", digitos_value, ALL_F);

    // two columns at once are ignored; a held '3' is accepted once
    strobes = 0;
    press_mask((16'b1 << kidx(1)) | (16'b1 << kidx(2)), 50);
    press(kidx(3), 120);
    press(K_HASH);
    chk("t6_single_value", digitos_value, 80'hFFFFFFFFFFFFFFFFFFF3);
    press(kidx(3), 500);
    press(K_HASH);
    chk("t6_long_hold_no_repeat", digitos_value, ALL_F);
    chk("t6_strobes", 80'(strobes), 80'd2);

    // reset in the middle of a press debounce
    press(kidx(8));
    press(K_HASH);
    chk("t6_pre_reset_value", digitos_value, 80'hFFFFFFFFFFFFFFFFFFF8);
    keys = 16'b1 << kidx(2);
    for (int i = 0; i < 60 && dut.state != 3'd2; i++) @(negedge clk);
    chk("t6_reached_deb_press", {77'd0, dut.state}, 80'd2);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_lin", {76'd0, lin_matrix}, 80'hF);
    chk("t6_rst_valid", {79'd0, digitos_valid}, 80'd0);
    chk("t6_rst_value", digitos_value, ALL_F);
    keys = '0;
    rst = 1'b0;
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
